div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Initiator side of the multicycle divider handshake (en/busy/done, q/r).
//  Accepts DIV/DIVU requests from the EX stage and launches one divider operation.
//  Stalls issue while the operation is in flight and captures q/r into result registers (HI/LO).
//  Flushes are absorbed by draining the uncancellable divider.
// PARAMETERS
//  WDOG_CYCLES  64  cycles allowed in WAIT/DRAIN before the watchdog aborts; must be >= 40
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  issue_valid  in   1   EX presents a divide request
//  issue_ready  out  1   controller accepts the request this cycle
//  issue_signed in   1   1 = DIV (signed), 0 = DIVU
//  issue_a      in   32  dividend
//  issue_b      in   32  divisor
//  flush        in   1   pipeline flush; discard the in-flight operation
//  stall        out  1   pipeline stall; high in LAUNCH/WAIT/DRAIN
//  res_valid    out  1   one-cycle pulse: res_q/res_r updated
//  res_q        out  32  quotient register (LO)
//  res_r        out  32  remainder register (HI)
//  wdog_err     out  1   sticky; set on watchdog expiry, cleared only by rst
//  div_en       out  1   to divider; registered one-cycle start pulse
//  div_signed   out  1   to divider hassign
//  div_a        out  32  to divider a; held from accept until return to IDLE
//  div_b        out  32  to divider b; held from accept until return to IDLE
//  div_busy     in   1   from divider; observed for the ready gate only
//  div_done     in   1   from divider; one-cycle pulse, q/r valid only while high
//  div_q        in   32  from divider quotient
//  div_r        in   32  from divider remainder
// BEHAVIOUR
//  Reset: state=IDLE; div_en=0; res_valid=0; res_q=0; res_r=0; wdog_err=0; div_a/div_b/div_signed=0.
//  issue_ready = (state==IDLE) & ~flush & ~div_busy. Accept = issue_valid & issue_ready.
//  Flush in the same cycle as a request: nothing accepted.
//  FSM:
//   IDLE   -> LAUNCH on accept; latch operands; div_en<=1.
//   LAUNCH -> div_en<=0. Go to WAIT, or to DRAIN if flush.
//             The divider samples en at the edge that leaves LAUNCH.
//   WAIT   -> on div_done: res_q<=div_q, res_r<=div_r, res_valid<=1, go to IDLE.
//             flush without div_done: go to DRAIN.
//             flush together with div_done: result discarded, go to IDLE.
//   DRAIN  -> on div_done: go to IDLE; no capture, no res_valid.
//  div_done is ignored in IDLE and LAUNCH: its value is undefined until the first operation completes.
//  Latency: divider done 34 cycles after it samples en. res_valid is high 36 cycles after the accept edge.
//   Back-to-back: a new accept is legal in the cycle after res_valid.
//  Watchdog: counter cleared on entry to LAUNCH, increments in WAIT/DRAIN.
//   At WDOG_CYCLES-1: wdog_err<=1, go to IDLE, no res_valid.
//  res_q/res_r hold their value until the next capture. flush never alters them.
//  Async rst mid-operation: immediate return to reset values. The divider shares rst.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined: accept with issue_b==0 skips the divider.
//   Next cycle: res_q=32'hFFFF_FFFF, res_r=issue_a, res_valid=1; state stays IDLE; stall never asserted.
//   A flush in the accept cycle blocks the accept, as for any request.
//  Not defined: zero divisor goes through the divider like any operand; result is whatever the divider returns.
// STRUCTURE
//  div_ctrl_pkg: state encoding (IDLE/LAUNCH/WAIT/DRAIN), DIV_W=32, WDOG counter width.
//  Sub-module div_ctrl_wdog: clear/enable/expire counter parameterised by WDOG_CYCLES.
// TESTING
//  1 DIVU a=100, b=7 -> div_en pulse 1 cycle after accept.
//    res_valid 36 cycles after accept; res_q=14, res_r=2; stall high throughout.
//  2 DIV a=-7 (FFFF_FFF9), b=2 -> res_q=FFFF_FFFD, res_r=FFFF_FFFF.
//  3 DIVU 50/5 then flush 10 cycles later -> DRAIN; no res_valid; res_q/res_r unchanged.
//    issue_ready returns the cycle after div_done.
//  4 Two back-to-back DIVU (9/2, then 20/6 issued the cycle after res_valid)
//    -> res (4,1), then (3,2); no lost or duplicate res_valid.
//  5 rst pulsed 15 cycles into WAIT -> all outputs at reset values;
//    fresh DIVU 8/3 -> res_q=2, res_r=2.
//  6 b=0, a=123: with DIV_ZERO_FAST_EN -> res_valid next cycle, q=FFFF_FFFF, r=123, no div_en.
//    Without it -> div_en pulse, same values after the full divider latency.
//    Divider model that never asserts done -> wdog_err=1 at cycle 64.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider issue controller: controller states,
// datapath width and watchdog counter sizing.
package div_ctrl_pkg;

    localparam int DIV_W               = 32;
    localparam int WDOG_CYCLES_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Counter width needed to reach cycles-1.
    function automatic int wdog_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    localparam int WDOG_W = wdog_width(WDOG_CYCLES_DEFAULT);

endpackage

// File: rtl/div_ctrl_wdog.sv
// Watchdog counter: cleared when an operation launches, counts while the
// controller waits on the divider, and flags expiry at WDOG_CYCLES-1.
module div_ctrl_wdog
    import div_ctrl_pkg::*;
#(
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int             CW   = wdog_width(WDOG_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] count_reg;

    assign expire = en & (count_reg == LAST);

    // Saturates at LAST so a stuck expiry cannot wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en & ~expire) begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Initiator side of the multicycle divider handshake: launches one DIV/DIVU,
// stalls EX until done, captures q/r into HI/LO. Optional DIV_ZERO_FAST_EN.
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             issue_signed,
    input  logic [DIV_W-1:0] issue_a,
    input  logic [DIV_W-1:0] issue_b,
    input  logic             flush,
    output logic             stall,
    output logic             res_valid,
    output logic [DIV_W-1:0] res_q,
    output logic [DIV_W-1:0] res_r,
    output logic             wdog_err,
    output logic             div_en,
    output logic             div_signed,
    output logic [DIV_W-1:0] div_a,
    output logic [DIV_W-1:0] div_b,
    input  logic             div_busy,
    input  logic             div_done,
    input  logic [DIV_W-1:0] div_q,
    input  logic [DIV_W-1:0] div_r
);

    state_t state_reg, state_next;
    logic   accept;
    logic   launch;
    logic   capture;
    logic   wdog_trip;
    logic   wdog_en;
    logic   wdog_expire;
    logic   zero_fast;

    assign issue_ready = (state_reg == ST_IDLE) & ~flush & ~div_busy;
    assign accept      = issue_valid & issue_ready;
    assign stall       = (state_reg != ST_IDLE);
    assign wdog_en     = (state_reg == ST_WAIT) | (state_reg == ST_DRAIN);

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = accept & (issue_b == '0);
`else
    assign zero_fast = 1'b0;
`endif

    div_ctrl_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (launch),
        .en     (wdog_en),
        .expire (wdog_expire)
    );

    // div_done is only trusted in WAIT/DRAIN; before the first completion it is undefined.
    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        capture    = 1'b0;
        wdog_trip  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept & ~zero_fast) begin
                    state_next = ST_LAUNCH;
                    launch     = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_next = flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done) begin
                    state_next = ST_IDLE;
                    capture    = ~flush;
                end else if (wdog_expire) begin
                    state_next = ST_IDLE;
                    wdog_trip  = 1'b1;
                end else if (flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (div_done) begin
                    state_next = ST_IDLE;
                end else if (wdog_expire) begin
                    state_next = ST_IDLE;
                    wdog_trip  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            div_en     <= 1'b0;
            res_valid  <= 1'b0;
            res_q      <= '0;
            res_r      <= '0;
            wdog_err   <= 1'b0;
            div_signed <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
        end else begin
            state_reg <= state_next;
            div_en    <= launch;
            res_valid <= capture | zero_fast;
            if (wdog_trip) begin
                wdog_err <= 1'b1;
            end
            // Operands stay put for the whole flight so the divider can resample freely.
            if (launch) begin
                div_signed <= issue_signed;
                div_a      <= issue_a;
                div_b      <= issue_b;
            end
            if (capture) begin
                res_q <= div_q;
                res_r <= div_r;
            end else if (zero_fast) begin
                res_q <= '1;
                res_r <= issue_a;
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: divider stub, transaction-level reference model,
// per-cycle compare, directed scenarios followed by randomized traffic.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic        issue_signed = 1'b0;
    logic [31:0] issue_a = '0;
    logic [31:0] issue_b = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        res_valid;
    logic [31:0] res_q;
    logic [31:0] res_r;
    logic        wdog_err;
    logic        div_en;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;

    always #5 clk = ~clk;

    div_issue_ctrl #(.WDOG_CYCLES(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_signed (issue_signed),
        .issue_a      (issue_a),
        .issue_b      (issue_b),
        .flush        (flush),
        .stall        (stall),
        .res_valid    (res_valid),
        .res_q        (res_q),
        .res_r        (res_r),
        .wdog_err     (wdog_err),
        .div_en       (div_en),
        .div_signed   (div_signed),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .div_q        (div_q),
        .div_r        (div_r)
    );

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Architectural divide result {q, r}; zero divisor and signed overflow follow RISC-V.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Divider stub: samples en, asserts done 34 cycles later; hang suppresses done.
    int          dcnt;
    logic        dv_done;
    logic        dv_s;
    logic [31:0] dv_a, dv_b;
    bit          hang = 1'b0;
    logic [63:0] dv_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt    <= 0;
            dv_done <= 1'b0;
        end else begin
            dv_done <= 1'b0;
            if (div_en) begin
                dcnt <= 34;
                dv_a <= div_a;
                dv_b <= div_b;
                dv_s <= div_signed;
            end else if (dcnt != 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1 && !hang) dv_done <= 1'b1;
            end
        end
    end

    assign div_busy = (dcnt != 0);
    assign div_done = dv_done;
    assign dv_res   = ref_div(dv_s, dv_a, dv_b);
    assign div_q    = dv_done ? dv_res[63:32] : 32'hDEAD_BEEF;
    assign div_r    = dv_done ? dv_res[31:0]  : 32'hBAAD_F00D;

    // Reference model: an accepted op occupies cycles [start, end]; any flush in that
    // window discards it; the result appears the cycle after end.
    int          cyc = 0;
    bit          op_active = 1'b0;
    int          op_start = 0;
    int          op_end = 0;
    bit          op_cancel = 1'b0;
    bit          op_hang = 1'b0;
    logic        op_s = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [63:0] pend = '0;
    logic [31:0] exp_q = '0, exp_r = '0;
    bit          exp_wdog = 1'b0;
    int          rv_cycle = -1;
    int          last_acc_edge = 0;
    int          ntxn = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            op_active = 1'b0;
            exp_q     = '0;
            exp_r     = '0;
            exp_wdog  = 1'b0;
            rv_cycle  = -1;
        end else begin
            int p;
            p = cyc;
            if (op_active) begin
                if (flush) op_cancel = 1'b1;
                if (p == op_end) begin
                    op_active = 1'b0;
                    if (op_hang) begin
                        exp_wdog = 1'b1;
                    end else if (!op_cancel) begin
                        exp_q    = pend[63:32];
                        exp_r    = pend[31:0];
                        rv_cycle = p + 1;
                    end
                end
            end else if (issue_valid && !flush && !div_busy) begin
                ntxn++;
                $display("txn %0d cycle %0d: %s a=%h b=%h", ntxn, p,
                         issue_signed ? "DIV " : "DIVU", issue_a, issue_b);
                last_acc_edge = p + 1;
                if (FAST && issue_b == 32'd0) begin
                    exp_q    = 32'hFFFF_FFFF;
                    exp_r    = issue_a;
                    rv_cycle = p + 1;
                end else begin
                    op_active = 1'b1;
                    op_start  = p + 1;
                    op_hang   = hang;
                    op_end    = hang ? p + 65 : p + 36;
                    op_cancel = 1'b0;
                    op_s      = issue_signed;
                    op_a      = issue_a;
                    op_b      = issue_b;
                    pend      = ref_div(issue_signed, issue_a, issue_b);
                end
            end
            cyc = p + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // DUT event observation, used by the directed latency checks.
    int rv_seen = 0, den_seen = 0;
    int last_rv_cyc = 0, last_den_cyc = 0, wdog_cyc = 0;
    logic wdog_prev = 1'b0;

    always @(negedge clk) begin
        chk("stall",       32'(stall),       32'(op_active));
        chk("div_en",      32'(div_en),      32'(op_active && cyc == op_start));
        chk("res_valid",   32'(res_valid),   32'(cyc == rv_cycle));
        chk("res_q",       res_q,            exp_q);
        chk("res_r",       res_r,            exp_r);
        chk("wdog_err",    32'(wdog_err),    32'(exp_wdog));
        chk("issue_ready", 32'(issue_ready), 32'(!op_active && !flush && !div_busy));
        if (op_active) begin
            chk("div_a",      div_a,            op_a);
            chk("div_b",      div_b,            op_b);
            chk("div_signed", 32'(div_signed),  32'(op_s));
        end
        if (res_valid) begin
            rv_seen++;
            last_rv_cyc = cyc;
        end
        if (div_en) begin
            den_seen++;
            last_den_cyc = cyc;
        end
        if (wdog_err && !wdog_prev) wdog_cyc = cyc;
        wdog_prev = wdog_err;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (op_active && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (op_active) begin
            errors++;
            $display("FAIL wait_idle cycle %0d: still busy after %0d cycles, required idle", cyc, n);
        end
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        issue_valid  = 1'b1;
        issue_signed = s;
        issue_a      = a;
        issue_b      = b;
        step();
        issue_valid  = 1'b0;
    endtask

    task automatic pulse_rst();
        #1 rst = 1'b1;
        #3 rst = 1'b0;
        step();
    endtask

    initial begin
        int rv0, den0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        step();
        chk("reset res_q", res_q, 32'd0);
        chk("reset wdog",  32'(wdog_err), 32'd0);

        // 1: DIVU 100/7
        issue(1'b0, 32'd100, 32'd7);
        wait_idle();
        step();
        chk("t1 q",        res_q, 32'd14);
        chk("t1 r",        res_r, 32'd2);
        chk("t1 model q",  exp_q, 32'd14);
        chk("t1 en lat",   32'(last_den_cyc - last_acc_edge), 32'd0);
        chk("t1 res lat",  32'(last_rv_cyc - last_acc_edge), 32'd36);

        // 2: DIV -7/2
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        step();
        chk("t2 q", res_q, 32'hFFFF_FFFD);
        chk("t2 r", res_r, 32'hFFFF_FFFF);

        // 3: flush mid-flight drains without a result
        rv0 = rv_seen;
        issue(1'b0, 32'd50, 32'd5);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_idle();
        step();
        chk("t3 no res", 32'(rv_seen - rv0), 32'd0);
        chk("t3 q kept", res_q, 32'hFFFF_FFFD);
        chk("t3 r kept", res_r, 32'hFFFF_FFFF);

        // 4: back-to-back, second issued the cycle after res_valid
        rv0 = rv_seen;
        issue(1'b0, 32'd9, 32'd2);
        wait_idle();
        chk("t4a q", res_q, 32'd4);
        chk("t4a r", res_r, 32'd1);
        step();
        issue(1'b0, 32'd20, 32'd6);
        wait_idle();
        step();
        chk("t4b q",     res_q, 32'd3);
        chk("t4b r",     res_r, 32'd2);
        chk("t4 pulses", 32'(rv_seen - rv0), 32'd2);

        // 5: reset 15 cycles into WAIT, then a fresh op
        issue(1'b0, 32'd100, 32'd3);
        repeat (16) step();
        pulse_rst();
        chk("t5 q rst",   res_q, 32'd0);
        chk("t5 r rst",   res_r, 32'd0);
        chk("t5 stall",   32'(stall), 32'd0);
        chk("t5 div_a",   div_a, 32'd0);
        issue(1'b0, 32'd8, 32'd3);
        wait_idle();
        step();
        chk("t5 q", res_q, 32'd2);
        chk("t5 r", res_r, 32'd2);

        // 6: zero divisor
        den0 = den_seen;
        issue(1'b0, 32'd123, 32'd0);
        wait_idle();
        step();
        chk("t6 q", res_q, 32'hFFFF_FFFF);
        chk("t6 r", res_r, 32'd123);
        if (FAST) begin
            chk("t6 fast en",  32'(den_seen - den0), 32'd0);
            chk("t6 fast lat", 32'(last_rv_cyc - last_acc_edge), 32'd0);
        end else begin
            chk("t6 en",  32'(den_seen - den0), 32'd1);
            chk("t6 lat", 32'(last_rv_cyc - last_acc_edge), 32'd36);
        end

        // 6b: divider never completes -> watchdog after 64 WAIT cycles
        hang = 1'b1;
        rv0  = rv_seen;
        issue(1'b0, 32'd10, 32'd3);
        wait_idle();
        step();
        hang = 1'b0;
        chk("t6 wdog",     32'(wdog_err), 32'd1);
        chk("t6 wdog lat", 32'(wdog_cyc - last_acc_edge), 32'd65);
        chk("t6 wdog res", 32'(rv_seen - rv0), 32'd0);
        chk("t6 wdog q",   res_q, 32'hFFFF_FFFF);
        pulse_rst();
        chk("t6 wdog clr", 32'(wdog_err), 32'd0);

        // Randomized traffic with stray flushes and zero divisors
        for (int i = 0; i < 1500; i++) begin
            int sel;
            issue_valid  = ($urandom_range(0, 2) == 0);
            issue_signed = $urandom_range(0, 1) == 1;
            issue_a      = $urandom;
            sel          = $urandom_range(0, 7);
            issue_b      = (sel == 0) ? 32'd0 :
                           (sel < 3)  ? 32'($urandom_range(1, 20)) :
                           (sel == 3) ? 32'hFFFF_FFFF : $urandom;
            if (sel == 3 && $urandom_range(0, 1) == 1) issue_a = 32'h8000_0000;
            flush        = ($urandom_range(0, 39) == 0);
            step();
        end
        issue_valid = 1'b0;
        flush       = 1'b0;
        wait_idle();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
